display_scanner: RTL

DISPLAY_SCANNER -- requirements
Module: display_scanner

---
 rtl/display_scanner.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/display_scanner.sv
// Multiplexed 7-segment scanner: time-slices DIGITS digits, double-buffers loaded values per frame.
// Latency: a load becomes visible at the first frame boundary after it; outputs decode registered state.
// Backpressure: none; load is a fire-and-forget strobe, later loads overwrite an unconsumed shadow value.
//
// Ports:
//   clk, reset       - single clock, asynchronous active-high reset
//   bcd_in, sign_in  - BCD digits (nibble 0 = units) and sign (1 = negative), captured on load
//   load             - one-cycle capture strobe into the shadow register
//   segments         - abcdefg, bit6 = a, active-high
//   display_select   - active-low digit enables, bit k = digit k
//   frame_done       - one-cycle pulse on the first cycle of digit 0 after each frame boundary
//
// Optional feature: define DISPLAY_LZB_EN to blank leading zero digits (digit 0 always shown,
// minus sign stays on the top digit).

module display_scanner #(
    parameter int DIGITS        = 4,
    parameter int REFRESH_TICKS = 10000,
    parameter int BLANK_TICKS   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  sign_in,
    input  logic                  load,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     display_select,
    output logic                  frame_done
);

    localparam int TW = $clog2(REFRESH_TICKS);
    localparam int IW = $clog2(DIGITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_TICKS - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TW-1:0]       tick_q, tick_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
    logic                shadow_sign_q, shadow_sign_d;
    logic [4*DIGITS-1:0] active_bcd_q, active_bcd_d;
    logic                active_sign_q, active_sign_d;
    logic                pending_q, pending_d;
    logic                frame_done_q, frame_done_d;

    logic                tick_wrap;
    logic                boundary;

    always_comb begin
        tick_wrap = (tick_q == TICK_LAST);
        boundary  = tick_wrap && (idx_q == IDX_LAST);

        tick_d = tick_wrap ? '0 : tick_q + 1'b1;

        idx_d = idx_q;
        if (tick_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Shadow always accepts the newest load.
        shadow_bcd_d  = shadow_bcd_q;
        shadow_sign_d = shadow_sign_q;
        if (load) begin
            shadow_bcd_d  = bcd_in;
            shadow_sign_d = sign_in;
        end

        // Active copy only moves on a frame boundary, and it takes the shadow
        // as it stood before the edge; a load on that same edge stays pending
        // for the following frame.
        active_bcd_d  = active_bcd_q;
        active_sign_d = active_sign_q;
        if (boundary && pending_q) begin
            active_bcd_d  = shadow_bcd_q;
            active_sign_d = shadow_sign_q;
        end

        pending_d = pending_q;
        if (boundary) begin
            pending_d = 1'b0;
        end
        if (load) begin
            pending_d = 1'b1;
        end

        frame_done_d = boundary;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q        <= '0;
            idx_q         <= '0;
            shadow_bcd_q  <= '0;
            shadow_sign_q <= 1'b0;
            active_bcd_q  <= '0;
            active_sign_q <= 1'b0;
            pending_q     <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            tick_q        <= tick_d;
            idx_q         <= idx_d;
            shadow_bcd_q  <= shadow_bcd_d;
            shadow_sign_q <= shadow_sign_d;
            active_bcd_q  <= active_bcd_d;
            active_sign_q <= active_sign_d;
            pending_q     <= pending_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (purely combinational from registered state)
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1110011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    logic in_blank;

    generate
        if (BLANK_TICKS == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (tick_q < TW'(BLANK_TICKS));
        end
    endgenerate

`ifdef DISPLAY_LZB_EN
    // lz_mask[k] = every magnitude nibble from k upward is zero. With a
    // negative value the top nibble is replaced by the minus sign, so it is
    // treated as zero for the purpose of blanking the digits below it.
    logic [DIGITS-1:0] lz_mask;

    always_comb begin
        logic lz_run;
        lz_run  = 1'b1;
        lz_mask = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (!((k == DIGITS - 1) && active_sign_q) && (active_bcd_q[4*k +: 4] != 4'd0)) begin
                lz_run = 1'b0;
            end
            lz_mask[k] = lz_run;
        end
    end
`endif

    logic [3:0] cur_nib;
    logic [6:0] digit_seg;

    always_comb begin
        cur_nib   = active_bcd_q[{idx_q, 2'b00} +: 4];
        digit_seg = seg_of(cur_nib);

        if (active_sign_q && (idx_q == IDX_LAST)) begin
            digit_seg = 7'b0000001;
        end
`ifdef DISPLAY_LZB_EN
        else if ((idx_q != '0) && lz_mask[idx_q]) begin
            digit_seg = 7'b0000000;
        end
`endif

        if (in_blank) begin
            segments       = 7'b0000000;
            display_select = '1;
        end else begin
            segments       = digit_seg;
            display_select = ~(DIGITS'(1) << idx_q);
        end
    end

    assign frame_done = frame_done_q;

endmodule
